// File: rtl/write_number.sv
// write_number: transmit side of the number link.
//
// Serialises a NUM_BYTES*8-bit word onto a UART tx line as 8N1 frames.
// The least significant byte goes first, and within each byte bit 0 goes
// first. The bit-level transmitter is built in.
//
// Ports
//   clk    in   system clock, all logic on posedge
//   rst    in   synchronous, active-high reset
//   data   in   word to send, sampled only when a word is accepted
//   valid  in   producer has a word on data
//   ready  out  block can accept a word this cycle (IDLE or DONE)
//   tx     out  registered UART serial output, idle high
//   busy   out  a frame is in flight (START, DATA or STOP)
//   done   out  one-cycle pulse after the last stop bit has finished
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | line idle high, waiting for valid
// S_START | start bit (tx low) for CLKS_PER_BIT cycles
// S_DATA  | 8 data bits, each held CLKS_PER_BIT cycles, bit 0 first
// S_STOP  | stop bit (tx high) for CLKS_PER_BIT cycles
// S_DONE  | single-cycle completion; may accept the next word directly

module write_number #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int NUM_BYTES    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_BYTES*8-1:0] data,
  input  logic                   valid,
  output logic                   ready,
  output logic                   tx,
  output logic                   busy,
  output logic                   done
);

  localparam int WORD_W = NUM_BYTES * 8;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BYTE_W = $clog2(NUM_BYTES) + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);
  localparam logic [2:0]        BIT_LAST  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [BYTE_W-1:0]   byte_q, byte_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                baud_last;

  assign baud_last = (baud_q == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        baud_d  = '0;
        bit_d   = '0;
        byte_d  = '0;
        if (valid) begin
          state_d = S_START;
          shift_d = data;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          // Shifting the whole word leaves the next byte's bit 0 at the
          // bottom once eight bits have gone, so no byte mux is needed.
          shift_d = {1'b0, shift_q[WORD_W-1:1]};
          if (bit_q == BIT_LAST) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (byte_q == BYTE_LAST) begin
            byte_d  = '0;
            state_d = S_DONE;
          end else begin
            byte_d  = byte_q + 1'b1;
            state_d = S_START;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // tx is decoded from the next state so the line changes on the same
    // edge the FSM does, keeping the output registered without a lag cycle.
    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx    = tx_q;
  assign ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy  = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);
  assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_write_number.sv
module tb_write_number;

  localparam int C     = 16;
  localparam int NB    = 4;
  localparam int FRAME = NB * 10 * C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data = '0;
  logic        valid = 1'b0;
  logic        ready, tx, busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;

  write_number #(.CLKS_PER_BIT(C), .NUM_BYTES(NB)) dut (
    .clk(clk), .rst(rst), .data(data), .valid(valid),
    .ready(ready), .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  // Offers one word for a single cycle, then scrambles data.
  task automatic accept_word(input logic [31:0] d);
    @(negedge clk);
    valid = 1'b1;
    data  = d;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    data  = $urandom;
  endtask

  // Independent UART decoder: samples each bit slot in its middle.
  task automatic recv_word(output logic [31:0] w, output int fall_c,
                           output bit frame_ok, output bit tmo);
    int n;
    int slot;
    logic b;
    n = 0; w = '0; frame_ok = 1'b1; tmo = 1'b0; fall_c = 0;
    while (tx !== 1'b0) begin
      @(negedge clk);
      n++;
      if (n > 4 * C) begin
        tmo = 1'b1;
        return;
      end
    end
    fall_c = cyc;
    for (int j = 0; j < NB * 10; j++) begin
      repeat ((j == 0) ? C / 2 : C) @(negedge clk);
      b = tx;
      slot = j % 10;
      if (slot == 0) begin
        if (b !== 1'b0) frame_ok = 1'b0;
      end else if (slot == 9) begin
        if (b !== 1'b1) frame_ok = 1'b0;
      end else begin
        w[(j / 10) * 8 + slot - 1] = b;
      end
    end
  endtask

  task automatic wait_done(output int dc, output bit tmo);
    int n;
    n = 0; tmo = 1'b0; dc = 0;
    while (done !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 4 * C) begin
        tmo = 1'b1;
        return;
      end
    end
    dc = cyc;
  endtask

  task automatic test_reset();
    int d0, lows;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({tx, ready, busy, done} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_idle: got tx/ready/busy/done=%b expected 1100", {tx, ready, busy, done});
    end

    accept_word(32'hA5A5A5A5);
    repeat (13 * C) @(negedge clk);
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({tx, ready, busy, done} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_midframe: got tx/ready/busy/done=%b expected 1100", {tx, ready, busy, done});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    lows = 0;
    repeat (FRAME + 2 * C) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    n_checks++;
    if (lows != 0) begin
      n_fail++;
      $display("FAIL reset_line_quiet: got %0d active cycles expected 0", lows);
    end
    n_checks++;
    if (done_cnt != d0) begin
      n_fail++;
      $display("FAIL reset_no_done: got %0d done pulses expected 0", done_cnt - d0);
    end
  endtask

  task automatic test_single_word();
    logic [31:0] w;
    int f, dc, d0;
    bit ok, t1, t2;
    d0 = done_cnt;
    accept_word(32'h04030201);
    n_checks++;
    if ({tx, ready, busy, done} !== 4'b0010) begin
      n_fail++;
      $display("FAIL single_after_accept: got tx/ready/busy/done=%b expected 0010", {tx, ready, busy, done});
    end
    recv_word(w, f, ok, t1);
    wait_done(dc, t2);
    n_checks++;
    if (t1 || t2 || !ok || w !== 32'h04030201) begin
      n_fail++;
      $display("FAIL single_word: got %h (frame_ok=%0d tmo=%0d%0d) expected 04030201", w, ok, t1, t2);
    end
    n_checks++;
    if (dc - f != FRAME) begin
      n_fail++;
      $display("FAIL single_done_latency: got %0d expected %0d", dc - f, FRAME);
    end
    n_checks++;
    if ({tx, ready, busy} !== 3'b110) begin
      n_fail++;
      $display("FAIL single_done_cycle: got tx/ready/busy=%b expected 110", {tx, ready, busy});
    end
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || ready !== 1'b1 || done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL single_done_pulse: got done=%b ready=%b pulses=%0d expected 0 1 1", done, ready, done_cnt - d0);
    end
  endtask

  task automatic test_bit_timing();
    int f, off, edges, bad;
    logic prev;
    logic [7:0] b0;
    int dc;
    bit t;
    accept_word(32'h000000AA);
    f = cyc;
    prev = tx;
    edges = 0; bad = 0; b0 = '0;
    repeat (FRAME) begin
      @(negedge clk);
      off = cyc - f;
      if (tx !== prev) begin
        edges++;
        if (off % C != 0) bad++;
        prev = tx;
      end
      if (off % C == C / 2 && off / C >= 1 && off / C <= 8) b0[off / C - 1] = tx;
    end
    wait_done(dc, t);
    n_checks++;
    if (bad != 0 || edges != 13) begin
      n_fail++;
      $display("FAIL bit_edges: got %0d edges %0d off-grid expected 13 edges 0 off-grid", edges, bad);
    end
    n_checks++;
    if (b0 !== 8'hAA) begin
      n_fail++;
      $display("FAIL bit_pattern: got %b expected 10101010", b0);
    end
    n_checks++;
    if (t || dc - f != FRAME) begin
      n_fail++;
      $display("FAIL bit_done_latency: got %0d expected %0d", dc - f, FRAME);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    logic [31:0] w;
    int f, dc, rdy_err, d0, extra;
    bit ok, t1, t2;
    rdy_err = 0;
    accept_word(32'hDEADBEEF);
    fork
      recv_word(w, f, ok, t1);
      begin
        repeat (5 * C) @(negedge clk);
        valid = 1'b1;
        data  = 32'h12345678;
        repeat (20 * C) begin
          @(negedge clk);
          if (ready !== 1'b0) rdy_err++;
        end
        valid = 1'b0;
        repeat (10 * C) begin
          @(negedge clk);
          if (ready !== 1'b0) rdy_err++;
        end
      end
    join
    wait_done(dc, t2);
    d0 = done_cnt;
    n_checks++;
    if (t1 || !ok || w !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL busy_word: got %h (frame_ok=%0d) expected deadbeef", w, ok);
    end
    n_checks++;
    if (rdy_err != 0 || t2) begin
      n_fail++;
      $display("FAIL busy_ready_low: got %0d ready-high cycles expected 0", rdy_err);
    end
    extra = 0;
    repeat (2 * C) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) extra++;
    end
    n_checks++;
    if (extra != 0 || done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL busy_no_queue: got %0d active cycles after done expected 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w1, w2;
    int f1, f2, d1, d2;
    bit ok1, ok2, ta, tb, tc, td;
    @(negedge clk);
    valid = 1'b1;
    data  = 32'h11223344;
    @(posedge clk);
    @(negedge clk);
    data = 32'h55667788;
    recv_word(w1, f1, ok1, ta);
    wait_done(d1, tb);
    n_checks++;
    if (tx !== 1'b1 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_done_cycle: got tx=%b ready=%b expected 1 1", tx, ready);
    end
    @(negedge clk);
    valid = 1'b0;
    n_checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_restart: got tx=%b busy=%b expected 0 1", tx, busy);
    end
    recv_word(w2, f2, ok2, tc);
    wait_done(d2, td);
    n_checks++;
    if (ta || !ok1 || w1 !== 32'h11223344) begin
      n_fail++;
      $display("FAIL b2b_word1: got %h expected 11223344", w1);
    end
    n_checks++;
    if (tc || !ok2 || w2 !== 32'h55667788) begin
      n_fail++;
      $display("FAIL b2b_word2: got %h expected 55667788", w2);
    end
    n_checks++;
    if (tb || td || f2 - d1 != 1 || d2 - f2 != FRAME) begin
      n_fail++;
      $display("FAIL b2b_gap: got start %0d after done, frame %0d expected 1, %0d", f2 - d1, d2 - f2, FRAME);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_loopback();
    logic [31:0] w;
    int f, dc;
    bit ok, t1, t2;
    accept_word(32'hCAFEF00D);
    recv_word(w, f, ok, t1);
    wait_done(dc, t2);
    n_checks++;
    if (t1 || t2 || !ok || w !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL loopback_word: got %h expected cafef00d", w);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_bit_timing();
    test_busy_ignore();
    test_back_to_back();
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
